// File: rtl/nco_stream_pkg.sv
// Shared types, default sizing and the write-side rounding helper for the
// NCO frame streamer.
package nco_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Sample widths used by round_sat; the streamer's MPR/OW default to these.
    localparam int NCO_MPR = 18;
    localparam int NCO_OW  = 16;
    localparam int RND_D   = NCO_MPR - NCO_OW;

    localparam int DEF_FRAME_LEN  = 1024;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_NFW        = 8;

    // Counter widths: position in frame, FIFO fill, total samples in a run.
    localparam int DEF_FCNT_W = $clog2(DEF_FRAME_LEN);
    localparam int DEF_FILL_W = $clog2(DEF_FIFO_DEPTH) + 1;
    localparam int DEF_TOT_W  = DEF_NFW + DEF_FCNT_W;

    // Round half up by adding 2^(D-1) and dropping D bits (taking the upper
    // slice is the arithmetic shift), then clamp to the OW-bit range. One
    // guard bit keeps the rounding add from overflowing.
    function automatic logic [NCO_OW-1:0] round_sat(input logic [NCO_MPR-1:0] x);
        logic [NCO_MPR:0] sum;
        logic [NCO_OW:0]  q;
        sum = {x[NCO_MPR-1], x} + (NCO_MPR+1)'(1 << (RND_D - 1));
        q   = sum[NCO_MPR:RND_D];
        if (q[NCO_OW] != q[NCO_OW-1])
            round_sat = q[NCO_OW] ? {1'b1, {(NCO_OW-1){1'b0}}} : {1'b0, {(NCO_OW-1){1'b1}}};
        else
            round_sat = q[NCO_OW-1:0];
    endfunction

endpackage

// File: rtl/nco_stream_fifo.sv
// Synchronous first-word-fall-through FIFO: rd_data shows the head entry
// whenever empty is low; rd_en pops it.
module nco_stream_fifo
    import nco_stream_pkg::*;
#(
    parameter int W     = 2 * NCO_OW,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   fill_q;
    logic          wr_ok;
    logic          rd_ok;

    // Writes to a full FIFO and reads from an empty one are dropped.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Storage array, left unreset; only pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr_q] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   fill_q <= fill_q + (AW+1)'(1);
                2'b01:   fill_q <= fill_q - (AW+1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign empty   = (fill_q == '0);
    assign full    = (fill_q == (AW+1)'(DEPTH));
    assign fill    = fill_q;

endmodule

// File: rtl/nco_frame_streamer.sv
// Throttles the NCO via its clock-enable, rounds each quadrature sample to
// OW bits, buffers it and re-emits it as framed Avalon-ST packets.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | enabling the NCO until FRAME_LEN*num_frames samples are accepted
// DRAIN | NCO stopped; emptying the FIFO until the final eop transfers
module nco_frame_streamer
    import nco_stream_pkg::*;
#(
    parameter int MPR        = NCO_MPR,
    parameter int OW         = NCO_OW,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int NFW        = DEF_NFW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [NFW-1:0] num_frames,
    output logic           busy,
    output logic           done,
    output logic           nco_clken,
    input  logic           nco_valid,
    input  logic [MPR-1:0] nco_sin,
    input  logic [MPR-1:0] nco_cos,
    output logic           src_valid,
    input  logic           src_ready,
    output logic [OW-1:0]  src_real,
    output logic [OW-1:0]  src_imag,
    output logic           src_sop,
    output logic           src_eop
);

    localparam int FCNT_W = $clog2(FRAME_LEN);
    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TOT_W  = NFW + FCNT_W;

    state_t              state_q;
    state_t              state_d;
    logic [TOT_W-1:0]    remain_q;
    logic [FCNT_W-1:0]   out_cnt_q;
    logic                done_q;

    logic                fifo_empty;
    logic                fifo_full;
    logic [FILL_W-1:0]   fifo_fill;
    logic [2*OW-1:0]     fifo_rd_data;
    logic [2*OW-1:0]     fifo_wr_data;

    logic                start_ok;
    logic                start_zero;
    logic                can_take;
    logic                accept;
    logic                last_accept;
    logic                xfer;
    logic                drain_exit;

    assign start_ok    = (state_q == IDLE) && start && (num_frames != '0);
    assign start_zero  = (state_q == IDLE) && start && (num_frames == '0);
    assign can_take    = !fifo_full && (remain_q != '0);
    assign accept      = (state_q == RUN) && can_take && nco_valid;
    assign last_accept = accept && (remain_q == TOT_W'(1));
    assign xfer        = src_valid && src_ready;
    // The last sample of a run is always an eop; leave once it is the only entry and leaves.
    assign drain_exit  = (state_q == DRAIN) && xfer && src_eop && (fifo_fill == FILL_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and NCO enable.
    always_comb begin
        state_d   = state_q;
        nco_clken = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok)
                    state_d = RUN;
            end
            RUN: begin
                nco_clken = can_take;
                if (last_accept)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_exit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Remaining-sample down-counter, frame position counter and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            remain_q  <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= drain_exit || start_zero;
            if (start_ok) begin
                remain_q  <= {num_frames, {FCNT_W{1'b0}}};
                out_cnt_q <= '0;
            end else begin
                if (accept)
                    remain_q <= remain_q - TOT_W'(1);
                if (xfer)
                    out_cnt_q <= out_cnt_q + FCNT_W'(1);
            end
        end
    end

    assign fifo_wr_data = {round_sat(nco_cos), round_sat(nco_sin)};

    nco_stream_fifo #(
        .W     (2 * OW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (fifo_wr_data),
        .rd_en   (xfer),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .fill    (fifo_fill)
    );

    // Data fields are forced to zero while nothing is presented so stale
    // storage never shows on the bus.
    assign src_valid = !fifo_empty;
    assign src_real  = fifo_empty ? '0 : fifo_rd_data[2*OW-1:OW];
    assign src_imag  = fifo_empty ? '0 : fifo_rd_data[OW-1:0];
    assign src_sop   = src_valid && (out_cnt_q == '0);
    assign src_eop   = src_valid && (out_cnt_q == FCNT_W'(FRAME_LEN - 1));

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_nco_frame_streamer.sv
// Directed bench for nco_frame_streamer with FRAME_LEN=8 and a clock-enabled
// NCO model that has a 6-cycle invalid warm-up.
module tb_nco_frame_streamer;

    localparam int MPR = 18;
    localparam int OW  = 16;
    localparam int FL  = 8;
    localparam int NFW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [NFW-1:0] num_frames;
    logic           busy;
    logic           done;
    logic           nco_clken;
    logic           nco_valid;
    logic [MPR-1:0] nco_sin;
    logic [MPR-1:0] nco_cos;
    logic           src_valid;
    logic           src_ready;
    logic [OW-1:0]  src_real;
    logic [OW-1:0]  src_imag;
    logic           src_sop;
    logic           src_eop;

    always #5 clk = ~clk;

    nco_frame_streamer #(
        .MPR        (MPR),
        .OW         (OW),
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (16),
        .NFW        (NFW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_frames (num_frames),
        .busy       (busy),
        .done       (done),
        .nco_clken  (nco_clken),
        .nco_valid  (nco_valid),
        .nco_sin    (nco_sin),
        .nco_cos    (nco_cos),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_real   (src_real),
        .src_imag   (src_imag),
        .src_sop    (src_sop),
        .src_eop    (src_eop)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-computed rounding table: (x + 2) >>> 2, saturated to 16 bits.
    int tbl_in  [8] = '{131071, -131072, 5, 6, -6, 0, 2, -3};
    int tbl_out [8] = '{32767,  -32768,  1, 2, -1, 0, 1, -1};

    int             cyc, n, acc, beats, total, done_cnt, valid_cnt;
    int             ready_mode, val_mode, fill_at_full, clken_over;
    bit             seen_full, stall_prev;
    logic [34:0]    held;
    logic [31:0]    exp_q [$];
    bit             start_req, rst_req;
    logic [NFW-1:0] nf_req;

    // One clock: drive inputs at negedge, then score what the next posedge does.
    task automatic tick();
        int k;
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        reset      = rst_req;
        start      = start_req;
        num_frames = nf_req;
        k = n - 6;
        nco_valid = (n >= 6);
        if (n < 6) begin
            nco_cos = 18'(12345);
            nco_sin = 18'(-999);
        end else if (val_mode == 1) begin
            nco_cos = 18'(tbl_in[k % 8]);
            nco_sin = 18'(tbl_in[(k + 3) % 8]);
        end else begin
            nco_cos = 18'(148 * k + 1);
            nco_sin = 18'(-44 * k - 2);
        end
        src_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
        #1;
        if (reset) begin
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev)
            chk("hold", {src_valid, src_sop, src_eop, src_real, src_imag}, held);
        if (src_valid)
            valid_cnt++;
        if (nco_clken && acc >= total)
            clken_over++;
        if (busy && !nco_clken && acc < total && !seen_full) begin
            seen_full    = 1'b1;
            fill_at_full = acc - beats;
        end
        if (nco_clken) begin
            if (nco_valid) begin
                if (val_mode == 1)
                    e = {16'(tbl_out[k % 8]), 16'(tbl_out[(k + 3) % 8])};
                else
                    e = {16'(37 * k), 16'(-11 * k)};
                exp_q.push_back(e);
                acc++;
            end
            n++;
        end
        if (src_valid && src_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk(val_mode == 1 ? "round_re" : "real", src_real, e[31:16]);
                chk(val_mode == 1 ? "round_im" : "imag", src_imag, e[15:0]);
                chk("sop", src_sop, (beats % FL) == 0);
                chk("eop", src_eop, (beats % FL) == FL - 1);
            end
            beats++;
        end
        stall_prev = src_valid && !src_ready;
        held       = {src_valid, src_sop, src_eop, src_real, src_imag};
        if (done) begin
            done_cnt++;
            chk("busy_at_done", busy, 0);
        end
    endtask

    task automatic clear_model(input int nf, input int rm, input int vm);
        ready_mode = rm;
        val_mode   = vm;
        n = 0; acc = 0; beats = 0; done_cnt = 0; valid_cnt = 0;
        seen_full = 1'b0; fill_at_full = -1; clken_over = 0;
        total = nf * FL;
        stall_prev = 1'b0;
        exp_q.delete();
    endtask

    task automatic run(input int nf, input int rm, input int vm, input bit poke);
        clear_model(nf, rm, vm);
        start_req = 1'b1;
        nf_req    = NFW'(nf);
        tick();
        start_req = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            tick();
            if (i == 0)
                chk("busy_after_start", busy, 1);
            if (poke && i == 15) begin
                start_req = 1'b1;
                nf_req    = NFW'(1);
            end else if (poke && i == 16) begin
                start_req = 1'b0;
            end
        end
        if (done_cnt == 0)
            chk("run_timeout", done_cnt, 1);
        repeat (5) tick();
        chk("beats", beats, total);
        chk("done_pulses", done_cnt, 1);
        chk("accepts", acc, total);
        chk("q_left", exp_q.size(), 0);
        chk("clken_over", clken_over, 0);
        chk("busy_end", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_clken"}, nco_clken, 0);
        chk({tag, "_valid"}, src_valid, 0);
        chk({tag, "_sop"},   src_sop, 0);
        chk({tag, "_eop"},   src_eop, 0);
        chk({tag, "_real"},  src_real, 0);
        chk({tag, "_imag"},  src_imag, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_frames = '0;
        nco_valid = 1'b0; nco_sin = '0; nco_cos = '0; src_ready = 1'b1;
        cyc = 0; start_req = 1'b0; nf_req = '0; rst_req = 1'b1;
        clear_model(0, 0, 0);
        repeat (2) tick();
        rst_req = 1'b0;
        tick();
        chk_reset_vals("rst");

        // single frame, free-flowing sink
        run(1, 0, 0, 0);

        // three frames into a 1-in-4 ready sink: FIFO must fill and throttle
        run(3, 1, 0, 0);
        chk("full_seen", seen_full, 1);
        chk("fill_at_stall", fill_at_full, 16);

        // rounding/saturation table through the datapath
        run(1, 0, 1, 0);

        // multi-frame run with an ignored start mid-run
        run(3, 0, 0, 1);

        // reset after five accepted samples
        clear_model(1, 0, 0);
        start_req = 1'b1;
        nf_req    = NFW'(1);
        tick();
        start_req = 1'b0;
        for (int i = 0; i < 200 && acc < 5; i++)
            tick();
        chk("pre_reset_accepts", acc, 5);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tick();
        chk_reset_vals("midrst");
        repeat (3) tick();
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_no_valid", src_valid, 0);
        run(1, 0, 0, 0);

        // zero-frame request
        clear_model(0, 0, 0);
        start_req = 1'b1;
        nf_req    = '0;
        tick();
        start_req = 1'b0;
        tick();
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_clken", nco_clken, 0);
        chk("zero_valid", src_valid, 0);
        repeat (4) tick();
        chk("zero_done_pulses", done_cnt, 1);
        chk("zero_valid_cnt", valid_cnt, 0);
        chk("zero_accepts", acc, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
